// File: rtl/ttrng_pkg.sv
// Shared definitions for the ttrng request scheduler: FSM encoding and
// the selector / sample widths of the ttrng entropy source.
package ttrng_pkg;

  localparam int SEL_W = 2;
  localparam int SMP_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_RESP   = 2'd3
  } state_t;

  // A single requester still needs a 1-bit id field.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: picks the first set request at or
// after ptr, wrapping modulo NREQ.
module rr_arbiter
  import ttrng_pkg::*;
#(
  parameter  int NREQ = 4,
  localparam int IDW  = id_width(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  grant_id,
  output logic            any
);

  int   w_idx;
  logic w_found;

  always_comb begin
    grant    = '0;
    grant_id = '0;
    w_found  = 1'b0;
    w_idx    = 0;
    for (int k = 0; k < NREQ; k++) begin
      w_idx = (int'(ptr) + k) % NREQ;
      if (!w_found && req[w_idx]) begin
        grant[w_idx] = 1'b1;
        grant_id     = IDW'(w_idx);
        w_found      = 1'b1;
      end else begin
        w_found = w_found;
      end
    end
  end

  assign any = w_found;

endmodule

// File: rtl/ttrng_sched.sv
// Shares one ttrng source among NREQ requesters: select, settle, XOR-fold
// FOLD samples into a byte, and return it over a valid/ready channel.
module ttrng_sched
  import ttrng_pkg::*;
#(
  parameter  int NREQ   = 4,
  parameter  int SETTLE = 3,
  parameter  int FOLD   = 2,
  localparam int IDW    = id_width(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [SEL_W*NREQ-1:0] req_sel,
  output logic [NREQ-1:0]       req_ready,
  output logic                  rsp_valid,
  output logic [IDW-1:0]        rsp_id,
  output logic [SMP_W-1:0]      rsp_data,
  input  logic                  rsp_ready,
  output logic [SEL_W-1:0]      rng_sel,
  input  logic [SMP_W-1:0]      rng_number,
  output logic                  busy
);

  localparam int CNT_MAX = (SETTLE > FOLD) ? SETTLE : FOLD;
  localparam int CW      = $clog2(CNT_MAX + 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [IDW-1:0]   r_ptr;
  logic [IDW-1:0]   r_id;
  logic [CW-1:0]    r_cnt;
  logic [SMP_W-1:0] r_acc;
  logic [SMP_W-1:0] r_rsp_data;
  logic [IDW-1:0]   r_rsp_id;
  logic             r_rsp_valid;
  logic [SEL_W-1:0] r_rng_sel;
  logic [NREQ-1:0]  w_grant;
  logic [IDW-1:0]   w_grant_id;
  logic             w_any;
  logic             w_accept;
  logic             w_cnt_zero;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req      (req_valid),
    .ptr      (r_ptr),
    .grant    (w_grant),
    .grant_id (w_grant_id),
    .any      (w_any)
  );

  // Grants are only offered in IDLE and never while reset is asserted.
  assign w_accept   = (r_state == ST_IDLE) && w_any && !rst;
  assign req_ready  = w_accept ? w_grant : '0;
  assign w_cnt_zero = (r_cnt == '0);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:   if (w_accept)   w_state_nxt = ST_SETTLE; else w_state_nxt = ST_IDLE;
      ST_SETTLE: if (w_cnt_zero) w_state_nxt = ST_SAMPLE; else w_state_nxt = ST_SETTLE;
      ST_SAMPLE: if (w_cnt_zero) w_state_nxt = ST_RESP;   else w_state_nxt = ST_SAMPLE;
      ST_RESP:   if (rsp_ready)  w_state_nxt = ST_IDLE;   else w_state_nxt = ST_RESP;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_ptr       <= '0;
      r_id        <= '0;
      r_cnt       <= '0;
      r_acc       <= '0;
      r_rsp_data  <= '0;
      r_rsp_id    <= '0;
      r_rsp_valid <= 1'b0;
      r_rng_sel   <= '0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_id      <= w_grant_id;
            r_rng_sel <= req_sel[{w_grant_id, 1'b0} +: SEL_W];
            r_acc     <= '0;
            r_cnt     <= CW'(SETTLE - 1);
          end
        end
        ST_SETTLE: begin
          if (w_cnt_zero) r_cnt <= CW'(FOLD - 1);
          else            r_cnt <= r_cnt - CW'(1);
        end
        ST_SAMPLE: begin
          r_acc <= r_acc ^ rng_number;
          if (w_cnt_zero) begin
            r_rsp_data  <= r_acc ^ rng_number;
            r_rsp_id    <= r_id;
            r_rsp_valid <= 1'b1;
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        ST_RESP: begin
          // Rotate past the served requester so every waiter gets a turn.
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_ptr       <= (r_id == IDW'(NREQ - 1)) ? '0 : r_id + IDW'(1);
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_id    = r_rsp_id;
  assign rsp_data  = r_rsp_data;
  assign rng_sel   = r_rng_sel;
  assign busy      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_ttrng_sched.sv
// Scoreboard bench for ttrng_sched: default instance plus a
// NREQ=1/SETTLE=1/FOLD=1 corner instance sharing clock, reset and source.
module tb_ttrng_sched;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] rng_number;
  assign rng_number = 8'h10 + cyc[7:0];

  logic       rst;
  logic [3:0] req_valid;
  logic [7:0] req_sel;
  logic [3:0] req_ready;
  logic       rsp_valid;
  logic [1:0] rsp_id;
  logic [7:0] rsp_data;
  logic       rsp_ready;
  logic [1:0] rng_sel;
  logic       busy;

  logic       c_req_valid;
  logic [1:0] c_req_sel;
  logic       c_req_ready;
  logic       c_rsp_valid;
  logic [0:0] c_rsp_id;
  logic [7:0] c_rsp_data;
  logic       c_rsp_ready;
  logic [1:0] c_rng_sel;
  logic       c_busy;

  ttrng_sched #(.NREQ(4), .SETTLE(3), .FOLD(2)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_sel(req_sel),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .rsp_ready(rsp_ready), .rng_sel(rng_sel),
    .rng_number(rng_number), .busy(busy)
  );

  ttrng_sched #(.NREQ(1), .SETTLE(1), .FOLD(1)) dut_c (
    .clk(clk), .rst(rst), .req_valid(c_req_valid), .req_sel(c_req_sel),
    .req_ready(c_req_ready), .rsp_valid(c_rsp_valid), .rsp_id(c_rsp_id),
    .rsp_data(c_rsp_data), .rsp_ready(c_rsp_ready), .rng_sel(c_rng_sel),
    .rng_number(rng_number), .busy(c_busy)
  );

  typedef struct {
    int         id;
    logic [7:0] data;
    int         a;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Sample at an edge whose pre-edge cycle count is t has value 0x10+t.
  function automatic logic [7:0] exp_fold(input int a, input int settle, input int fold);
    logic [7:0] x;
    int         t;
    x = 8'h00;
    for (int k = 1; k <= fold; k++) begin
      t = a + settle + k;
      x = x ^ (8'h10 + t[7:0]);
    end
    return x;
  endfunction

  task automatic grant_wait(input int exp_id, input bit push, output int a);
    int k;
    k = 0;
    while (req_ready === 4'b0000 && k < 40) begin
      @(negedge clk); #1;
      k++;
    end
    n_checks++;
    if (req_ready !== 4'(1 << exp_id)) begin
      n_fail++;
      $display("FAIL grant: req_ready=%b expected %b", req_ready, 4'(1 << exp_id));
    end
    a = cyc;
    if (push) q.push_back('{id: exp_id, data: exp_fold(a, 3, 2), a: a});
  endtask

  task automatic rsp_wait(output logic [7:0] d_exp);
    exp_t e;
    int   k;
    k = 0;
    d_exp = 8'h00;
    @(negedge clk); #1;
    while (rsp_valid !== 1'b1 && k < 40) begin
      @(negedge clk); #1;
      k++;
    end
    n_checks++;
    if (q.size() == 0) begin
      n_fail++;
      $display("FAIL rsp_queue: got response with empty scoreboard, expected an entry");
    end else begin
      e = q.pop_front();
      d_exp = e.data;
      n_checks += 4;
      if (rsp_valid !== 1'b1) begin
        n_fail++; $display("FAIL rsp_valid: got %b expected 1", rsp_valid);
      end
      if (cyc - e.a !== 6) begin
        n_fail++; $display("FAIL latency: got %0d expected 6", cyc - e.a);
      end
      if (rsp_id !== 2'(e.id)) begin
        n_fail++; $display("FAIL rsp_id: got %0d expected %0d", rsp_id, e.id);
      end
      if (rsp_data !== e.data) begin
        n_fail++; $display("FAIL rsp_data: got %h expected %h", rsp_data, e.data);
      end
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    @(negedge clk); #1;
    n_checks += 7;
    if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL rst_req_ready: got %b expected 0000", req_ready); end
    if (rsp_valid !== 1'b0)    begin n_fail++; $display("FAIL rst_rsp_valid: got %b expected 0", rsp_valid); end
    if (rsp_id !== 2'd0)       begin n_fail++; $display("FAIL rst_rsp_id: got %0d expected 0", rsp_id); end
    if (rsp_data !== 8'h00)    begin n_fail++; $display("FAIL rst_rsp_data: got %h expected 00", rsp_data); end
    if (rng_sel !== 2'b00)     begin n_fail++; $display("FAIL rst_rng_sel: got %b expected 00", rng_sel); end
    if (busy !== 1'b0)         begin n_fail++; $display("FAIL rst_busy: got %b expected 0", busy); end
    if (c_busy !== 1'b0)       begin n_fail++; $display("FAIL rst_c_busy: got %b expected 0", c_busy); end
    rst = 1'b0; #1;
    n_checks++;
    if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL rel_req_ready: got %b expected 0001", req_ready); end
    req_valid = 4'b0000;
  endtask

  task automatic test_single();
    int         a;
    logic [7:0] d;
    req_sel = 8'b0001_0000; req_valid = 4'b0100; rsp_ready = 1'b1; #1;
    grant_wait(2, 1'b1, a);
    @(negedge clk);
    req_valid = 4'b0000; req_sel = 8'hFF; #1;
    n_checks += 2;
    if (rng_sel !== 2'b01) begin n_fail++; $display("FAIL single_rng_sel: got %b expected 01", rng_sel); end
    if (busy !== 1'b1)     begin n_fail++; $display("FAIL single_busy: got %b expected 1", busy); end
    rsp_wait(d);
    @(negedge clk); #1;
    n_checks += 3;
    if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL single_one_cycle: got %b expected 0", rsp_valid); end
    if (busy !== 1'b0)      begin n_fail++; $display("FAIL single_idle: got %b expected 0", busy); end
    if (rng_sel !== 2'b01)  begin n_fail++; $display("FAIL single_sel_hold: got %b expected 01", rng_sel); end
  endtask

  task automatic test_fairness();
    int         a;
    int         prev;
    logic [7:0] d;
    prev = 0;
    rsp_ready = 1'b1; req_valid = 4'b0000; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; req_valid = 4'b1111; #1;
    for (int i = 0; i < 6; i++) begin
      grant_wait(i % 4, 1'b1, a);
      if (i > 0) begin
        n_checks++;
        if (a - prev !== 7) begin n_fail++; $display("FAIL fair_period: got %0d expected 7", a - prev); end
      end
      prev = a;
      rsp_wait(d);
    end
    req_valid = 4'b0000;
  endtask

  task automatic test_backpressure();
    int         a;
    logic [7:0] d;
    @(negedge clk);
    req_valid = 4'b1001; rsp_ready = 1'b0; #1;
    grant_wait(3, 1'b1, a);
    rsp_wait(d);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); #1;
      n_checks += 4;
      if (rsp_valid !== 1'b1)   begin n_fail++; $display("FAIL bp_valid: got %b expected 1", rsp_valid); end
      if (rsp_id !== 2'd3)      begin n_fail++; $display("FAIL bp_id: got %0d expected 3", rsp_id); end
      if (rsp_data !== d)       begin n_fail++; $display("FAIL bp_data: got %h expected %h", rsp_data, d); end
      if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL bp_ready: got %b expected 0000", req_ready); end
    end
    rsp_ready = 1'b1;
    @(negedge clk); #1;
    n_checks += 3;
    if (rsp_valid !== 1'b0)    begin n_fail++; $display("FAIL bp_done: got %b expected 0", rsp_valid); end
    if (busy !== 1'b0)         begin n_fail++; $display("FAIL bp_idle: got %b expected 0", busy); end
    if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL bp_next: got %b expected 0001", req_ready); end
    req_valid = 4'b0000;
  endtask

  task automatic test_reset_mid();
    int         a;
    logic [7:0] d;
    req_valid = 4'b0010; rsp_ready = 1'b1; #1;
    grant_wait(1, 1'b1, a);
    @(negedge clk);
    req_valid = 4'b0000;
    rsp_wait(d);
    req_sel = 8'b0000_1100; req_valid = 4'b0110;
    grant_wait(2, 1'b0, a);
    repeat (4) @(negedge clk);
    #1;
    n_checks++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL mid_busy: got %b expected 1", busy); end
    rst = 1'b1; #1;
    n_checks++;
    if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL mid_rst_ready: got %b expected 0000", req_ready); end
    @(negedge clk); #1;
    n_checks += 3;
    if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL mid_no_rsp: got %b expected 0", rsp_valid); end
    if (busy !== 1'b0)      begin n_fail++; $display("FAIL mid_idle: got %b expected 0", busy); end
    if (rng_sel !== 2'b00)  begin n_fail++; $display("FAIL mid_sel: got %b expected 00", rng_sel); end
    rst = 1'b0; #1;
    n_checks++;
    if (req_ready !== 4'b0010) begin n_fail++; $display("FAIL mid_regrant: got %b expected 0010", req_ready); end
    grant_wait(1, 1'b1, a);
    @(negedge clk);
    req_valid = 4'b0000; #1;
    n_checks++;
    if (rng_sel !== 2'b11) begin n_fail++; $display("FAIL mid_rng_sel: got %b expected 11", rng_sel); end
    rsp_wait(d);
    n_checks++;
    if (q.size() !== 0) begin n_fail++; $display("FAIL mid_queue: got %0d entries expected 0", q.size()); end
  endtask

  task automatic test_corner();
    exp_t e;
    int   a;
    int   k;
    @(negedge clk);
    c_req_sel = 2'b10; c_req_valid = 1'b1; c_rsp_ready = 1'b1; #1;
    n_checks++;
    if (c_req_ready !== 1'b1) begin n_fail++; $display("FAIL c_ready: got %b expected 1", c_req_ready); end
    a = cyc;
    q.push_back('{id: 0, data: exp_fold(a, 1, 1), a: a});
    @(negedge clk);
    c_req_valid = 1'b0; #1;
    n_checks += 2;
    if (c_rng_sel !== 2'b10) begin n_fail++; $display("FAIL c_rng_sel: got %b expected 10", c_rng_sel); end
    if (c_busy !== 1'b1)     begin n_fail++; $display("FAIL c_busy: got %b expected 1", c_busy); end
    k = 0;
    while (c_rsp_valid !== 1'b1 && k < 20) begin
      @(negedge clk); #1;
      k++;
    end
    e = q.pop_front();
    n_checks += 4;
    if (c_rsp_valid !== 1'b1)    begin n_fail++; $display("FAIL c_rsp_valid: got %b expected 1", c_rsp_valid); end
    if (cyc - e.a !== 3)         begin n_fail++; $display("FAIL c_latency: got %0d expected 3", cyc - e.a); end
    if (c_rsp_id !== 1'(e.id))   begin n_fail++; $display("FAIL c_rsp_id: got %0d expected %0d", c_rsp_id, e.id); end
    if (c_rsp_data !== e.data)   begin n_fail++; $display("FAIL c_rsp_data: got %h expected %h", c_rsp_data, e.data); end
    @(negedge clk); #1;
    n_checks++;
    if (c_rsp_valid !== 1'b0) begin n_fail++; $display("FAIL c_one_cycle: got %b expected 0", c_rsp_valid); end
  endtask

  initial begin
    rst = 1'b1; req_valid = 4'b1111; req_sel = 8'h00; rsp_ready = 1'b0;
    c_req_valid = 1'b0; c_req_sel = 2'b00; c_rsp_ready = 1'b0;
    test_reset();
    test_single();
    test_fairness();
    test_backpressure();
    test_reset_mid();
    test_corner();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ttrng_sched.md
# ttrng_sched

Round-robin scheduler that shares one `ttrng` entropy source among several requesters. It drives the source's 2-bit selector and waits a settle interval. It then XOR-folds a fixed number of consecutive 8-bit samples into one result byte and returns that byte with the requester's id over a valid/ready response channel. It sits between the `ttrng` instance and the consumer logic inside `tt_um_ttrng`.

## Interface
Parameters:
- `NREQ`, 4: number of requesters, 1..8.
- `SETTLE`, 3: cycles to wait after the selector is driven, before the first sample; ≥1.
- `FOLD`, 2: number of consecutive samples XOR-folded per result; ≥1.

Ports (IDW = max(1, clog2(NREQ))):
- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  NREQ  per-requester request.
- `req_sel`  in  2*NREQ  requested selector; requester i uses bits [2i+1:2i].
- `req_ready`  out  NREQ  one-hot accept; the handshake completes on the edge where `req_valid[i] & req_ready[i]`.
- `rsp_valid`  out  1  result available.
- `rsp_id`  out  IDW  index of the served requester.
- `rsp_data`  out  8  folded random byte.
- `rsp_ready`  in  1  consumer accepts the result.
- `rng_sel`  out  2  to `ttrng.selector`.
- `rng_number`  in  8  from `ttrng.number`.
- `busy`  out  1  high in every state except IDLE.

## Operation
- FSM states: IDLE, SETTLE, SAMPLE, RESP.
- **IDLE**
  - `req_ready` is combinational: one-hot of the round-robin winner among the set `req_valid` bits.
  - The search starts at `ptr` and wraps modulo NREQ.
  - `req_ready` is all-zero if no request is pending or `rst` is high.
  - On the accept edge: latch `id`; `rng_sel <= req_sel[id]`; `acc <= 0`; `cnt <= SETTLE-1`; go to SETTLE.
- **SETTLE**
  - If `cnt == 0`: `cnt <= FOLD-1`, go to SAMPLE.
  - Else `cnt <= cnt-1`.
- **SAMPLE**
  - Each cycle `acc <= acc ^ rng_number`.
  - When `cnt == 0`: `rsp_data <= acc ^ rng_number`, `rsp_id <= id`, `rsp_valid <= 1`, go to RESP.
  - Else `cnt <= cnt-1`.
- **RESP**
  - `rsp_valid`, `rsp_id` and `rsp_data` are held stable until `rsp_ready`.
  - On the edge with `rsp_ready`: `rsp_valid <= 0`; `ptr <= (id+1) mod NREQ`; go to IDLE.
- `rng_sel` keeps its last value in IDLE and RESP. It changes only on an accept.
- `req_sel` is sampled only on the accept edge. Later changes have no effect on the transaction in flight.
- A `req_valid` that drops before it is granted is legal and has no effect.
- `rsp_data` is a plain 8-bit XOR with no carry. FOLD=1 returns the raw sample.

## Timing
- Reset values: state IDLE, `ptr` 0, `rsp_valid` 0, `rsp_id` 0, `rsp_data` 0x00, `rng_sel` 2'b00, `busy` 0, `req_ready` 0.
- Latency: with the accept on edge t0, `rsp_valid` rises after edge t0+SETTLE+FOLD.
  - Samples are taken on edges t0+SETTLE+1 … t0+SETTLE+FOLD.
  - With the defaults, `rsp_valid` is high after t5.
- Throughput: at most one transaction per SETTLE+FOLD+2 cycles (one RESP cycle, one IDLE cycle). There is no accept while RESP is stalled.
- Simultaneous requests: the lowest index at or after `ptr` wins. The others wait, and the pointer rotation guarantees each is served within NREQ grants.
- Simultaneous `rsp_ready` and a new `req_valid` in RESP: the response completes and the new request is considered in the following IDLE cycle.
- Reset mid-operation: the transaction is dropped with no response. All registers return to their reset values on the next edge.
- `rsp_ready` held high: `rsp_valid` lasts exactly one cycle.

## Structure
- Shared package `ttrng_pkg` holds:
  - the state encoding (IDLE=0, SETTLE=1, SAMPLE=2, RESP=3);
  - the selector width (2);
  - the sample width (8).
- Sub-module `rr_arbiter` (parameter NREQ):
  - inputs: `req` [NREQ], `ptr` [IDW];
  - outputs: one-hot `grant`, encoded `grant_id`, `any`.
  - It is purely combinational and instantiated once.
- Counter width is clog2(max(SETTLE, FOLD)+1).

## Test plan
- **Reset values:** assert `rst` for 2 cycles while `req_valid=4'b1111` → all outputs at reset values, `req_ready=0`. Release → `req_ready=4'b0001` in the first cycle.
- **Single request:**
  - Stimulus: `req_valid[2]=1`, `req_sel[5:4]=2'b01`; model drives `rng_number = 0x10 + cycle#`.
  - Required: `rng_sel=01` after the accept, `rsp_valid` after edge t0+5, `rsp_id=2`, `rsp_data` = XOR of the samples at t4 and t5.
- **Fairness:** all four requesters held valid, `rsp_ready=1` → grant order 0,1,2,3,0,1. Each response arrives every 7 cycles.
- **Backpressure:** `rsp_ready=0` for 10 cycles in RESP → `rsp_valid`, `rsp_id` and `rsp_data` stable, no `req_ready` asserted. `rsp_ready=1` → completes, IDLE on the next cycle.
- **Reset mid-SAMPLE:** pulse `rst` during SAMPLE → no `rsp_valid`. The pending requester is re-granted from `ptr=0`.
- **Parameter corners:** SETTLE=1, FOLD=1, NREQ=1 → `rsp_valid` 2 edges after the accept, `rsp_data` equals the single sample, `rsp_id=0`.
